stc0_stream_ctrl: RTL and testbench
===================================

# stc0_stream_ctrl

Wishbone-controlled sequencer for the stc0_core byte-stream ports, instantiated next to user_proj_example on the Caravel management Wishbone bus. Firmware pushes ingress bytes into a TX FIFO. The block paces them onto ID/IValid with a programmable inter-byte gap, captures ED/EValid into an RX FIFO, and owns the core's ARstb. It raises an interrupt when egress data is waiting.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone window base; the window is 256 bytes.
- FIFO_DEPTH, 8, depth of each FIFO; power of two, 2..16.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave strobes.
- wbs_sel_i  in  4  byte-lane enables for writes.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  read data; 0 whenever ack is low.
- wbs_ack_o  out  1  single-cycle acknowledge.
- core_arstb_o  out  1  drives stc0_core ARstb (active-low).
- core_id_o  out  8  ingress byte to stc0_core ID.
- core_ivalid_o  out  1  ingress valid to stc0_core IValid.
- core_ed_i  in  8  egress byte from stc0_core ED.
- core_evalid_i  in  1  egress valid from stc0_core EValid; synchronous to wb_clk_i.
- irq_o  out  1  interrupt.

## Operation
- Address decode: hit when wbs_adr_i[31:8] == BASE_ADDR[31:8]. Offset is adr[7:0].
  - Unmapped offsets inside the window are acked, read 0 and ignore writes.
  - Addresses outside the window are never acked.
- Writes apply per wbs_sel_i lane.
- Registers:
  - 0x00 CTRL:
    - [0] ENABLE
    - [1] CORE_RUN
    - [2] IRQ_EN
    - [3] FLUSH (self-clearing, reads 0)
    - [4] LOOPBACK (macro-dependent)
  - 0x04 STATUS:
    - [4:0] tx_count, [12:8] rx_count
    - [16] tx_full, [17] rx_empty
    - [24] TX_OVF, [25] RX_OVF (both sticky, W1C)
    - [26] busy (FSM not IDLE)
  - 0x08 TXDATA (write only):
    - Write with sel[0] pushes dat_i[7:0].
    - Push when full: byte dropped, TX_OVF set.
  - 0x0C RXDATA (read):
    - Returns {23'b0, valid, byte}.
    - Pops only when not empty.
    - Read when empty returns 0 and pops nothing.
  - 0x10 GAP: [7:0], the number of idle cycles between consecutive ingress bytes.
- core_arstb_o = CTRL.CORE_RUN, so the core is held in reset until firmware sets CORE_RUN.
- Ingress FSM (IDLE, SEND, WAIT). eligible = ENABLE & CORE_RUN & TX not empty.
  - IDLE: if eligible, pop TX and go to SEND.
  - SEND: core_ivalid_o=1 and core_id_o=popped byte, for exactly one cycle.
    - GAP==0 and eligible: pop again and stay in SEND (one byte per cycle).
    - GAP==0 and not eligible: go to IDLE.
    - GAP>0: load counter=GAP and go to WAIT.
  - WAIT: decrement the counter.
    - At counter==1: if eligible, pop and go to SEND; otherwise go to IDLE.
    - Net effect: exactly GAP low cycles between bytes.
- Egress: when CORE_RUN & core_evalid_i, push core_ed_i into RX.
  - RX full: byte dropped, RX_OVF set.
- TX and RX FIFOs each support a simultaneous push and pop in one cycle; counts are unchanged.
- FLUSH:
  - Empties both FIFOs on the next edge.
  - Forces the FSM to IDLE; core_ivalid_o is low the next cycle.
  - Overrides a push or pop in the same cycle.
- Clearing CORE_RUN or ENABLE:
  - A byte already in SEND completes its single cycle.
  - WAIT or SEND then returns to IDLE; the TX contents are kept.
- irq_o is registered: irq_o = IRQ_EN & ~rx_empty.

## Timing
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0
  - core_arstb_o=0, core_ivalid_o=0, core_id_o=0
  - irq_o=0
  - all registers 0, FIFOs empty, FSM in IDLE.
- Reset mid-transfer clears everything at the same edge.
- Bus cycles:
  - Ack is registered: request seen in cycle N, ack high in cycle N+1 for exactly one cycle.
  - A new request is accepted only while ack is low.
  - Register side effects (push, pop, W1C) occur at the N→N+1 edge.
- TX latency: TXDATA write seen in cycle N (idle FSM, eligible otherwise) → core_ivalid_o high in cycle N+2.
- RX latency: core_evalid_i in cycle N → rx_count and irq_o updated in cycle N+1 and N+2 respectively.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- STC0_STREAM_LOOPBACK_EN defined:
  - CTRL[4] LOOPBACK is implemented.
  - When set, bytes issued in SEND are pushed into RX instead of driving the core; core_ivalid_o stays 0.
  - core_ed_i/core_evalid_i are ignored.
  - RX-full drop and RX_OVF rules still apply.
- Undefined: CTRL[4] reads 0, writes are ignored, and no loopback logic exists.

## Test plan
- Reset, then read CTRL/STATUS → 0x0 and 0x0002_0000; core_arstb_o=0, irq_o=0.
- CTRL=0x3, GAP=0, write 0xA1, 0xB2, 0xC3 back-to-back → core_ivalid_o high 3 consecutive cycles carrying A1, B2, C3; busy returns 0.
- GAP=3, two bytes queued → exactly 3 low cycles between the two ivalid pulses.
- Drive core_evalid_i with 9 bytes 0x10..0x18, DEPTH=8, IRQ_EN=1 → rx_count=8, RX_OVF=1, irq_o=1. RXDATA reads return 0x110..0x117, then 0x000. Writing STATUS bit 25 clears RX_OVF.
- 8 bytes queued with ENABLE=0, then write FLUSH → tx_count=0, no ivalid pulse. A 9th push before the flush sets TX_OVF.
- Defined STC0_STREAM_LOOPBACK_EN, CTRL=0x13, write 0x5A → core_ivalid_o stays 0, RXDATA reads 0x15A.

Source files
------------

// File: rtl/stc0_stream_ctrl.sv
// Wishbone-controlled byte-stream sequencer for stc0_core: paced TX FIFO toward ID/IValid, RX FIFO from ED/EValid.
// Optional feature: define STC0_STREAM_LOOPBACK_EN to implement CTRL[4] LOOPBACK (SEND bytes go to RX instead of the core).
module stc0_stream_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        core_arstb_o,
    output logic [7:0]  core_id_o,
    output logic        core_ivalid_o,
    input  logic [7:0]  core_ed_i,
    input  logic        core_evalid_i,
    output logic        irq_o
);
    localparam int         AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;

    logic          ack_reg;
    logic [31:0]   dat_reg;
    logic          enable_reg, run_reg, irq_en_reg;
    logic [7:0]    gap_reg;
    logic          tx_ovf_reg, rx_ovf_reg, irq_reg;
    logic          ivalid_reg;
    logic [7:0]    id_reg;
    state_t        state_reg;
    logic [7:0]    cnt_reg;

    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
    logic [4:0]    tx_count_reg;
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [4:0]    rx_count_reg;

    logic        hit, req, wr, rd;
    logic [7:0]  off;
    logic        ctrl_wr, flush, status_w1c, tx_wr, rx_rd, gap_wr;
    logic        tx_empty, tx_full, rx_empty, rx_full;
    logic        run_ok, eligible, busy;
    logic        tx_pop, tx_push, tx_drop;
    logic        rx_in_valid, rx_push, rx_pop, rx_drop;
    logic [7:0]  rx_in_data;
    logic        lb_bit;
    logic [31:0] rdata;

    assign hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off  = wbs_adr_i[7:0];
    // A new request is only taken while the previous ack is low, so each access acks exactly once.
    assign req  = wbs_cyc_i & wbs_stb_i & hit & ~ack_reg;
    assign wr   = req & wbs_we_i;
    assign rd   = req & ~wbs_we_i;

    assign ctrl_wr    = wr & (off == 8'h00) & wbs_sel_i[0];
    assign flush      = ctrl_wr & wbs_dat_i[3];
    assign status_w1c = wr & (off == 8'h04) & wbs_sel_i[3];
    assign tx_wr      = wr & (off == 8'h08) & wbs_sel_i[0];
    assign rx_rd      = rd & (off == 8'h0C);
    assign gap_wr     = wr & (off == 8'h10) & wbs_sel_i[0];

    assign tx_empty = (tx_count_reg == 5'd0);
    assign tx_full  = (tx_count_reg == DEPTH_C);
    assign rx_empty = (rx_count_reg == 5'd0);
    assign rx_full  = (rx_count_reg == DEPTH_C);

    assign run_ok   = enable_reg & run_reg;
    assign eligible = run_ok & ~tx_empty;
    assign busy     = (state_reg != ST_IDLE);

    always_comb begin
        tx_pop = 1'b0;
        case (state_reg)
            ST_IDLE: tx_pop = eligible;
            ST_SEND: tx_pop = eligible & (gap_reg == 8'd0);
            ST_WAIT: tx_pop = eligible & (cnt_reg == 8'd1);
            default: tx_pop = 1'b0;
        endcase
        if (flush) begin
            tx_pop = 1'b0;
        end
    end

    assign tx_push = tx_wr & ~tx_full & ~flush;
    assign tx_drop = tx_wr & tx_full;

`ifdef STC0_STREAM_LOOPBACK_EN
    logic loopback_reg;
    assign lb_bit      = loopback_reg;
    // In loopback the byte presented during SEND is captured instead of the core's egress.
    assign rx_in_valid = loopback_reg ? (state_reg == ST_SEND) : (run_reg & core_evalid_i);
    assign rx_in_data  = loopback_reg ? id_reg : core_ed_i;
`else
    assign lb_bit      = 1'b0;
    assign rx_in_valid = run_reg & core_evalid_i;
    assign rx_in_data  = core_ed_i;
`endif

    assign rx_push = rx_in_valid & ~rx_full & ~flush;
    assign rx_drop = rx_in_valid & rx_full;
    assign rx_pop  = rx_rd & ~rx_empty & ~flush;

    always_comb begin
        rdata = 32'd0;
        case (off)
            8'h00: rdata = {27'd0, lb_bit, 1'b0, irq_en_reg, run_reg, enable_reg};
            8'h04: rdata = {5'd0, busy, rx_ovf_reg, tx_ovf_reg, 6'd0, rx_empty, tx_full,
                            3'd0, rx_count_reg, 3'd0, tx_count_reg};
            8'h0C: rdata = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_mem[rx_rd_ptr_reg]};
            8'h10: rdata = {24'd0, gap_reg};
            default: rdata = 32'd0;
        endcase
    end

    // FIFO storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge wb_clk_i) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr_reg] <= wbs_dat_i[7:0];
        end
        if (rx_push) begin
            rx_mem[rx_wr_ptr_reg] <= rx_in_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_reg       <= 1'b0;
            dat_reg       <= 32'd0;
            enable_reg    <= 1'b0;
            run_reg       <= 1'b0;
            irq_en_reg    <= 1'b0;
            gap_reg       <= 8'd0;
            tx_ovf_reg    <= 1'b0;
            rx_ovf_reg    <= 1'b0;
            irq_reg       <= 1'b0;
            ivalid_reg    <= 1'b0;
            id_reg        <= 8'd0;
            state_reg     <= ST_IDLE;
            cnt_reg       <= 8'd0;
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
            tx_count_reg  <= 5'd0;
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_count_reg  <= 5'd0;
`ifdef STC0_STREAM_LOOPBACK_EN
            loopback_reg  <= 1'b0;
`endif
        end else begin
            ack_reg <= req;
            dat_reg <= rd ? rdata : 32'd0;

            if (ctrl_wr) begin
                enable_reg <= wbs_dat_i[0];
                run_reg    <= wbs_dat_i[1];
                irq_en_reg <= wbs_dat_i[2];
`ifdef STC0_STREAM_LOOPBACK_EN
                loopback_reg <= wbs_dat_i[4];
`endif
            end
            if (gap_wr) begin
                gap_reg <= wbs_dat_i[7:0];
            end

            // A fresh overflow wins over a simultaneous clear so no drop goes unreported.
            if (tx_drop) begin
                tx_ovf_reg <= 1'b1;
            end else if (status_w1c && wbs_dat_i[24]) begin
                tx_ovf_reg <= 1'b0;
            end
            if (rx_drop) begin
                rx_ovf_reg <= 1'b1;
            end else if (status_w1c && wbs_dat_i[25]) begin
                rx_ovf_reg <= 1'b0;
            end

            irq_reg <= irq_en_reg & ~rx_empty;

            if (flush) begin
                tx_wr_ptr_reg <= '0;
                tx_rd_ptr_reg <= '0;
                tx_count_reg  <= 5'd0;
                rx_wr_ptr_reg <= '0;
                rx_rd_ptr_reg <= '0;
                rx_count_reg  <= 5'd0;
            end else begin
                if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
                if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
                case ({tx_push, tx_pop})
                    2'b10:   tx_count_reg <= tx_count_reg + 5'd1;
                    2'b01:   tx_count_reg <= tx_count_reg - 5'd1;
                    default: tx_count_reg <= tx_count_reg;
                endcase
                if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
                if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
                case ({rx_push, rx_pop})
                    2'b10:   rx_count_reg <= rx_count_reg + 5'd1;
                    2'b01:   rx_count_reg <= rx_count_reg - 5'd1;
                    default: rx_count_reg <= rx_count_reg;
                endcase
            end

            if (tx_pop) begin
                id_reg <= tx_mem[tx_rd_ptr_reg];
            end
            ivalid_reg <= tx_pop & ~lb_bit;

            if (flush) begin
                state_reg <= ST_IDLE;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (tx_pop) state_reg <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (tx_pop) begin
                            state_reg <= ST_SEND;
                        end else if ((gap_reg != 8'd0) && run_ok) begin
                            cnt_reg   <= gap_reg;
                            state_reg <= ST_WAIT;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    ST_WAIT: begin
                        if (!run_ok) begin
                            state_reg <= ST_IDLE;
                        end else if (cnt_reg == 8'd1) begin
                            state_reg <= tx_pop ? ST_SEND : ST_IDLE;
                        end else begin
                            cnt_reg <= cnt_reg - 8'd1;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign wbs_ack_o     = ack_reg;
    assign wbs_dat_o     = dat_reg;
    assign core_arstb_o  = run_reg;
    assign core_id_o     = id_reg;
    assign core_ivalid_o = ivalid_reg;
    assign irq_o         = irq_reg;

    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i[2:1], wbs_dat_i[31:26], wbs_dat_i[23:8]};

endmodule

// File: tb/tb_stc0_stream_ctrl.sv
// Self-checking bench for stc0_stream_ctrl: register vector table, ingress/egress scoreboards, timing corner sequences.
module tb_stc0_stream_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic [31:0] rdat;
    logic        ack;
    logic        arstb;
    logic [7:0]  id;
    logic        ivalid;
    logic [7:0]  ed;
    logic        evalid;
    logic        irq;

    always #5 clk = ~clk;

    stc0_stream_ctrl #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_dat_o(rdat), .wbs_ack_o(ack),
        .core_arstb_o(arstb), .core_id_o(id), .core_ivalid_o(ivalid),
        .core_ed_i(ed), .core_evalid_i(evalid), .irq_o(irq)
    );

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int last_req_cyc = 0;
    logic [7:0]  exp_tx_q [$];
    logic [31:0] exp_rx_q [$];
    int          pulse_cyc [$];
    logic [7:0]  exp_b;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Ingress scoreboard: every ivalid pulse must match the next byte the bench queued.
    always @(negedge clk) begin
        if (!rst && ivalid) begin
            pulse_cyc.push_back(cyc_cnt);
            checks++;
            if (exp_tx_q.size() == 0) begin
                errors++;
                $display("FAIL ivalid_unexpected actual id=%02h required no pulse", id);
            end else begin
                exp_b = exp_tx_q.pop_front();
                if (id !== exp_b) begin
                    errors++;
                    $display("FAIL ivalid_byte actual=%02h required=%02h", id, exp_b);
                end else begin
                    $display("ok   ivalid_byte %02h at cycle %0d", id, cyc_cnt);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end else begin
            $display("ok   %s %08h", name, act);
        end
    endtask

    task automatic wb_xfer(input logic w, input logic [7:0] off, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] r);
        int n;
        if (ack) begin
            @(posedge clk); #1;
        end
        adr = BASE | {24'd0, off}; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
        last_req_cyc = cyc_cnt;
        n = 0;
        r = 32'd0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ack && n < 8);
        if (!ack) begin
            checks++; errors++;
            $display("FAIL wb_ack_timeout actual=no ack required=ack off=%02h", off);
        end else begin
            r = rdat;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_xfer(1'b1, off, d, s, dummy);
    endtask

    task automatic wb_read(input logic [7:0] off, output logic [31:0] r);
        wb_xfer(1'b0, off, 32'd0, 4'hF, r);
    endtask

    task automatic wait_pulses(input int cnt, input int budget);
        int n = 0;
        while (pulse_cyc.size() < cnt && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (pulse_cyc.size() < cnt) begin
            checks++; errors++;
            $display("FAIL pulse_timeout actual=%0d required=%0d", pulse_cyc.size(), cnt);
        end
    endtask

    typedef struct {
        logic        w;
        logic [7:0]  off;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs [15];
    logic [31:0] r;
    logic [31:0] ctrl_rb;
    int          acks;

    initial begin
`ifdef STC0_STREAM_LOOPBACK_EN
        ctrl_rb = 32'h14;
`else
        ctrl_rb = 32'h04;
`endif
        vecs[0]  = '{1'b0, 8'h00, 32'h0,         4'h0, 32'h0,         "ctrl_reset"};
        vecs[1]  = '{1'b0, 8'h04, 32'h0,         4'h0, 32'h0002_0000, "status_reset"};
        vecs[2]  = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h0,         "gap_reset"};
        vecs[3]  = '{1'b1, 8'h10, 32'h0000_01A5, 4'h1, 32'h0,         "gap_write"};
        vecs[4]  = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h0000_00A5, "gap_readback"};
        vecs[5]  = '{1'b1, 8'h10, 32'h0000_3300, 4'h2, 32'h0,         "gap_lane1_write"};
        vecs[6]  = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h0000_00A5, "gap_lane_masked"};
        vecs[7]  = '{1'b1, 8'h40, 32'hFFFF_FFFF, 4'hF, 32'h0,         "unmapped_write"};
        vecs[8]  = '{1'b0, 8'h40, 32'h0,         4'h0, 32'h0,         "unmapped_read"};
        vecs[9]  = '{1'b0, 8'h08, 32'h0,         4'h0, 32'h0,         "txdata_read"};
        vecs[10] = '{1'b1, 8'h00, 32'h0000_001C, 4'h1, 32'h0,         "ctrl_write"};
        vecs[11] = '{1'b0, 8'h00, 32'h0,         4'h0, ctrl_rb,       "ctrl_readback"};
        vecs[12] = '{1'b1, 8'h00, 32'h0,         4'h1, 32'h0,         "ctrl_clear"};
        vecs[13] = '{1'b1, 8'h10, 32'h0,         4'h1, 32'h0,         "gap_clear"};
        vecs[14] = '{1'b0, 8'h10, 32'h0,         4'h0, 32'h0,         "gap_cleared"};

        cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0; ed = 0; evalid = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_arstb", {31'd0, arstb}, 32'd0);
        check("rst_ivalid", {31'd0, ivalid}, 32'd0);
        check("rst_id", {24'd0, id}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].w) begin
                wb_write(vecs[i].off, vecs[i].dat, vecs[i].sel);
            end else begin
                wb_read(vecs[i].off, r);
                check(vecs[i].name, r, vecs[i].exp);
            end
        end

        // Outside the 256-byte window: never acked.
        adr = BASE + 32'h100; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        acks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        cyc = 1'b0; stb = 1'b0;
        check("out_of_window_noack", 32'(acks), 32'd0);

        // Three bytes queued while disabled, then released at GAP=0: one per cycle.
        wb_write(8'h00, 32'h2, 4'h1);
        check("arstb_run", {31'd0, arstb}, 32'd1);
        pulse_cyc.delete();
        exp_tx_q.push_back(8'hA1); wb_write(8'h08, 32'hA1, 4'h1);
        exp_tx_q.push_back(8'hB2); wb_write(8'h08, 32'hB2, 4'h1);
        exp_tx_q.push_back(8'hC3); wb_write(8'h08, 32'hC3, 4'h1);
        wb_read(8'h04, r);
        check("status_tx3", r, 32'h0002_0003);
        wb_write(8'h00, 32'h3, 4'h1);
        wait_pulses(3, 40);
        repeat (3) @(posedge clk);
        #1;
        check("burst_pulses", 32'(pulse_cyc.size()), 32'd3);
        if (pulse_cyc.size() == 3) begin
            check("burst_consec_1", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd1);
            check("burst_consec_2", 32'(pulse_cyc[2] - pulse_cyc[1]), 32'd1);
        end
        wb_read(8'h04, r);
        check("burst_status_idle", r, 32'h0002_0000);

        // Write-to-ivalid latency with an idle, eligible FSM.
        pulse_cyc.delete();
        exp_tx_q.push_back(8'h77);
        wb_write(8'h08, 32'h77, 4'h1);
        wait_pulses(1, 20);
        if (pulse_cyc.size() >= 1) begin
            check("tx_latency", 32'(pulse_cyc[0] - last_req_cyc), 32'd2);
        end

        // GAP=3: three low cycles between pulses.
        wb_write(8'h00, 32'h2, 4'h1);
        wb_write(8'h10, 32'h3, 4'h1);
        exp_tx_q.push_back(8'h11); wb_write(8'h08, 32'h11, 4'h1);
        exp_tx_q.push_back(8'h22); wb_write(8'h08, 32'h22, 4'h1);
        pulse_cyc.delete();
        wb_write(8'h00, 32'h3, 4'h1);
        wait_pulses(2, 40);
        if (pulse_cyc.size() >= 2) begin
            check("gap3_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd4);
        end

        // Dropping ENABLE during WAIT returns to IDLE and keeps the queued byte.
        wb_write(8'h00, 32'h2, 4'h1);
        wb_write(8'h10, 32'h8, 4'h1);
        exp_tx_q.push_back(8'h33); wb_write(8'h08, 32'h33, 4'h1);
        exp_tx_q.push_back(8'h44); wb_write(8'h08, 32'h44, 4'h1);
        pulse_cyc.delete();
        wb_write(8'h00, 32'h3, 4'h1);
        wait_pulses(1, 20);
        wb_write(8'h00, 32'h2, 4'h1);
        repeat (12) @(posedge clk);
        #1;
        check("disable_pulses", 32'(pulse_cyc.size()), 32'd1);
        wb_read(8'h04, r);
        check("disable_status", r, 32'h0002_0001);
        wb_write(8'h00, 32'h3, 4'h1);
        wait_pulses(2, 20);
        check("disable_resume_q", 32'(exp_tx_q.size()), 32'd0);
        wb_write(8'h10, 32'h0, 4'h1);

        // RX latency: irq follows one cycle after rx_count.
        wb_write(8'h00, 32'h6, 4'h1);
        ed = 8'h01; evalid = 1'b1;
        exp_rx_q.push_back(32'h101);
        @(posedge clk); #1;
        evalid = 1'b0;
        @(negedge clk);
        check("irq_n1", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_n2", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        wb_read(8'h0C, r);
        check("rxdata_first", r, exp_rx_q.pop_front());

        // Nine egress bytes into an 8-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            ed = 8'(8'h10 + i); evalid = 1'b1;
            if (exp_rx_q.size() < 8) exp_rx_q.push_back({23'd0, 1'b1, ed});
            @(posedge clk); #1;
        end
        evalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rx_irq", {31'd0, irq}, 32'd1);
        wb_read(8'h04, r);
        check("rx_status_full", r, 32'h0200_0800);
        for (int i = 0; i < 9; i++) begin
            wb_read(8'h0C, r);
            check($sformatf("rxdata_%0d", i), r, (exp_rx_q.size() > 0) ? exp_rx_q.pop_front() : 32'd0);
        end
        wb_write(8'h04, 32'h0200_0000, 4'h8);
        wb_read(8'h04, r);
        check("rx_ovf_w1c", r, 32'h0002_0000);
        repeat (2) @(posedge clk);
        #1;
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Fill TX past full while disabled, then FLUSH: nothing is ever sent.
        wb_write(8'h00, 32'h2, 4'h1);
        pulse_cyc.delete();
        for (int i = 0; i < 9; i++) begin
            wb_write(8'h08, 32'(8'hE0 + i), 4'h1);
        end
        wb_read(8'h04, r);
        check("tx_full_status", r, 32'h0103_0008);
        wb_write(8'h00, 32'hA, 4'h1);
        wb_read(8'h04, r);
        check("flush_status", r, 32'h0102_0000);
        wb_write(8'h00, 32'h3, 4'h1);
        repeat (10) @(posedge clk);
        #1;
        check("flush_no_pulse", 32'(pulse_cyc.size()), 32'd0);
        wb_write(8'h04, 32'h0100_0000, 4'h8);
        wb_read(8'h04, r);
        check("tx_ovf_w1c", r, 32'h0002_0000);

`ifdef STC0_STREAM_LOOPBACK_EN
        wb_write(8'h00, 32'h13, 4'h1);
        pulse_cyc.delete();
        wb_write(8'h08, 32'h5A, 4'h1);
        repeat (5) @(posedge clk);
        #1;
        check("lb_no_ivalid", 32'(pulse_cyc.size()), 32'd0);
        wb_read(8'h0C, r);
        check("lb_rxdata", r, 32'h15A);
        wb_write(8'h00, 32'h3, 4'h1);
`endif

        // Reset in the middle of activity clears registers and FIFOs.
        wb_write(8'h00, 32'h2, 4'h1);
        wb_write(8'h08, 32'h66, 4'h1);
        wb_write(8'h08, 32'h67, 4'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_arstb", {31'd0, arstb}, 32'd0);
        wb_read(8'h00, r);
        check("midrst_ctrl", r, 32'd0);
        wb_read(8'h04, r);
        check("midrst_status", r, 32'h0002_0000);

        check("tx_scoreboard_empty", 32'(exp_tx_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
